// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, FSM states,
// source count and CTRL bit positions.
package int_ctrl_pkg;

  localparam int NSRC = 4;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_PEND   = 3'd1;
  localparam logic [2:0] ADDR_EOI    = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_VEC0   = 3'd4;
  localparam logic [2:0] ADDR_VEC1   = 3'd5;
  localparam logic [2:0] ADDR_VEC2   = 3'd6;
  localparam logic [2:0] ADDR_VEC3   = 3'd7;

  localparam int CTRL_GEN_BIT  = 0;
  localparam int CTRL_MASK_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: reports the lowest-index asserted request.
module int_prio_enc
  import int_ctrl_pkg::*;
(
  input  logic [NSRC-1:0] req_i,
  output logic [1:0]      idx_o,
  output logic            valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    // Scan from the top so the lowest set index is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 2'(i);
    end
  end

endmodule

// File: rtl/int_controller.sv
// Memory-mapped interrupt controller: edge capture, fixed priority, one-cycle
// request to the core, and a service lockout released by an EOI write.
module int_controller
  import int_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            sel,
  input  logic [2:0]      addr,
  input  logic            w_en,
  input  logic [7:0]      w_data,
  output logic [7:0]      r_data,
  output logic            int_req,
  output logic [7:0]      int_en,
  output logic [7:0]      int_vec
);

  logic [7:0]      ctrl_q, ctrl_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] prev_q;
  logic [7:0]      vec_q [NSRC];
  logic [1:0]      id_q;
  state_e          state_q;
  logic            int_req_q;
  logic [7:0]      int_vec_q;

  logic            wr, wr_ctrl, wr_pend, wr_eoi, wr_vec;
  logic [NSRC-1:0] rise, elig, clr_mask, w1c;
  logic [1:0]      win_idx;
  logic            win_vld;

  assign wr      = sel & w_en;
  assign wr_ctrl = wr && (addr == ADDR_CTRL);
  assign wr_pend = wr && (addr == ADDR_PEND);
  assign wr_eoi  = wr && (addr == ADDR_EOI);
  assign wr_vec  = wr && addr[2];

  assign rise = irq_in & ~prev_q;
  assign elig = ctrl_q[CTRL_GEN_BIT] ? (pend_q & ctrl_q[CTRL_MASK_LSB +: NSRC]) : '0;

  // The accepted source clears on the REQ->SERVICE edge; a coincident new
  // edge (or a coincident W1C) loses to the set term.
  assign clr_mask = ((state_q == ST_REQ) && ctrl_q[CTRL_GEN_BIT]) ? (NSRC'(1) << id_q) : '0;
  assign w1c      = wr_pend ? w_data[NSRC-1:0] : '0;
  assign pend_d   = (pend_q & ~clr_mask & ~w1c) | rise;

  assign ctrl_d = wr_ctrl ? {w_data[7:4], 3'b000, w_data[CTRL_GEN_BIT]} : ctrl_q;

  int_prio_enc u_prio (
    .req_i   (elig),
    .idx_o   (win_idx),
    .valid_o (win_vld)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
      pend_q <= '0;
      prev_q <= '0;
      for (int i = 0; i < NSRC; i++) vec_q[i] <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      pend_q <= pend_d;
      prev_q <= irq_in;
      for (int i = 0; i < NSRC; i++) begin
        if (wr_vec && (addr[1:0] == 2'(i))) vec_q[i] <= w_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      int_req_q <= 1'b0;
      int_vec_q <= '0;
      id_q      <= '0;
    end else begin
      int_req_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            state_q   <= ST_REQ;
            int_req_q <= 1'b1;
            int_vec_q <= vec_q[win_idx];
            id_q      <= win_idx;
          end
        end
        // Global enable still set during the request cycle means the core took it.
        ST_REQ:     state_q <= ctrl_q[CTRL_GEN_BIT] ? ST_SERVICE : ST_IDLE;
        ST_SERVICE: if (wr_eoi) state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    r_data = '0;
    if (sel) begin
      case (addr)
        ADDR_CTRL:   r_data = ctrl_q;
        ADDR_PEND:   r_data = {{(8-NSRC){1'b0}}, pend_q};
        ADDR_EOI:    r_data = '0;
        ADDR_STATUS: r_data = {(state_q == ST_SERVICE), 5'b00000, id_q};
        ADDR_VEC0:   r_data = vec_q[0];
        ADDR_VEC1:   r_data = vec_q[1];
        ADDR_VEC2:   r_data = vec_q[2];
        ADDR_VEC3:   r_data = vec_q[3];
        default:     r_data = '0;
      endcase
    end
  end

  assign int_req = int_req_q;
  assign int_en  = ctrl_q;
  assign int_vec = int_vec_q;

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: reset checks, a cycle table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_int_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       sel;
  logic [2:0] addr;
  logic       w_en;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       int_req;
  logic [7:0] int_en;
  logic [7:0] int_vec;

  int n_chk  = 0;
  int n_fail = 0;

  int_controller dut (
    .clock   (clock),
    .reset   (reset),
    .irq_in  (irq_in),
    .sel     (sel),
    .addr    (addr),
    .w_en    (w_en),
    .w_data  (w_data),
    .r_data  (r_data),
    .int_req (int_req),
    .int_en  (int_en),
    .int_vec (int_vec)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] irq;
    logic       sel;
    logic       w_en;
    logic [2:0] addr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    logic       exp_req;
    logic [7:0] exp_vec;
  } row_t;

  row_t tbl [10];

  // Behavioural model state: phase 0 idle, 1 request, 2 in service.
  int         m_phase;
  logic [7:0] m_ctrl;
  bit         m_pend [4];
  logic [7:0] m_vec  [4];
  bit         m_prev [4];
  int         m_id;
  bit         m_req;
  logic [7:0] m_vout;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    sel = 1'b1; w_en = 1'b1; addr = a; w_data = d;
    tick();
    sel = 1'b0; w_en = 1'b0;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [7:0] exp, input string name);
    sel = 1'b1; w_en = 1'b0; addr = a;
    #1;
    chk(name, r_data, exp);
    sel = 1'b0;
  endtask

  task automatic do_reset();
    sel = 1'b0; w_en = 1'b0; addr = '0; w_data = '0; irq_in = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  function automatic void model_reset();
    m_phase = 0; m_ctrl = '0; m_id = 0; m_req = 1'b0; m_vout = '0;
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 1'b0; m_vec[i] = '0; m_prev[i] = 1'b0;
    end
  endfunction

  function automatic logic [7:0] model_rd();
    logic [7:0] v;
    v = '0;
    if (sel) begin
      case (addr)
        3'd0: v = m_ctrl;
        3'd1: for (int i = 0; i < 4; i++) v[i] = m_pend[i];
        3'd2: v = '0;
        3'd3: v = {(m_phase == 2), 5'b00000, 2'(m_id)};
        default: v = m_vec[int'(addr) - 4];
      endcase
    end
    return v;
  endfunction

  // Advance the model across one rising edge using the inputs held this cycle.
  function automatic void model_step();
    bit rise [4];
    int winner;
    bit wr_now;
    wr_now = sel && w_en;
    winner = -1;
    for (int i = 0; i < 4; i++) rise[i] = irq_in[i] && !m_prev[i];
    if (m_ctrl[0]) begin
      for (int i = 0; i < 4; i++)
        if (winner < 0 && m_pend[i] && m_ctrl[4 + i]) winner = i;
    end
    m_req = 1'b0;
    case (m_phase)
      0: if (winner >= 0) begin
           m_phase = 1; m_req = 1'b1; m_vout = m_vec[winner]; m_id = winner;
         end
      1: if (m_ctrl[0]) begin m_phase = 2; m_pend[m_id] = 1'b0; end
         else m_phase = 0;
      default: if (wr_now && addr == 3'd2) m_phase = 0;
    endcase
    if (wr_now && addr == 3'd1)
      for (int i = 0; i < 4; i++) if (w_data[i]) m_pend[i] = 1'b0;
    for (int i = 0; i < 4; i++) if (rise[i]) m_pend[i] = 1'b1;
    if (wr_now && addr == 3'd0) m_ctrl = {w_data[7:4], 3'b000, w_data[0]};
    if (wr_now && addr >= 3'd4) m_vec[int'(addr) - 4] = w_data;
    for (int i = 0; i < 4; i++) m_prev[i] = irq_in[i];
  endfunction

  initial begin
    tbl[0] = '{4'h0, 1'b1, 1'b1, 3'd0, 8'h11, 8'h00, 1'b0, 8'h00};
    tbl[1] = '{4'h0, 1'b1, 1'b1, 3'd4, 8'h40, 8'h00, 1'b0, 8'h00};
    tbl[2] = '{4'h1, 1'b1, 1'b0, 3'd1, 8'h00, 8'h00, 1'b0, 8'h00};
    tbl[3] = '{4'h0, 1'b1, 1'b0, 3'd1, 8'h00, 8'h01, 1'b1, 8'h40};
    tbl[4] = '{4'h0, 1'b1, 1'b0, 3'd3, 8'h00, 8'h00, 1'b0, 8'h40};
    tbl[5] = '{4'h0, 1'b1, 1'b0, 3'd3, 8'h00, 8'h80, 1'b0, 8'h40};
    tbl[6] = '{4'h0, 1'b1, 1'b0, 3'd1, 8'h00, 8'h00, 1'b0, 8'h40};
    tbl[7] = '{4'h0, 1'b1, 1'b1, 3'd2, 8'h00, 8'h00, 1'b0, 8'h40};
    tbl[8] = '{4'h0, 1'b1, 1'b0, 3'd3, 8'h00, 8'h00, 1'b0, 8'h40};
    tbl[9] = '{4'h0, 1'b1, 1'b0, 3'd4, 8'h00, 8'h40, 1'b0, 8'h40};

    // Reset state
    sel = 1'b0; w_en = 1'b0; addr = '0; w_data = '0; irq_in = '0;
    reset = 1'b1;
    tick(); tick();
    chk("rst_int_req", {7'b0, int_req}, 8'h00);
    chk("rst_int_en", int_en, 8'h00);
    chk("rst_int_vec", int_vec, 8'h00);
    reset = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) rd_chk(3'(a), 8'h00, $sformatf("rst_rd%0d", a));

    // Globally disabled: edge is captured but never issued
    irq_in = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("dis_no_req", {7'b0, int_req}, 8'h00);
    end
    rd_chk(3'd1, 8'h01, "dis_pend");
    irq_in = 4'b0000;
    tick();
    irq_in = 4'b0001;
    wr(3'd1, 8'h01);
    rd_chk(3'd1, 8'h01, "set_beats_w1c");
    irq_in = 4'b0000;
    wr(3'd1, 8'h01);
    rd_chk(3'd1, 8'h00, "w1c_clears");
    wr(3'd3, 8'hFF);
    rd_chk(3'd3, 8'h00, "status_ro");

    // Table: basic request/service/EOI on source 0
    do_reset();
    for (int i = 0; i < 10; i++) begin
      irq_in = tbl[i].irq; sel = tbl[i].sel; w_en = tbl[i].w_en;
      addr = tbl[i].addr; w_data = tbl[i].wd;
      #1;
      chk($sformatf("tbl%0d_rd", i), r_data, tbl[i].exp_rd);
      tick();
      chk($sformatf("tbl%0d_req", i), {7'b0, int_req}, {7'b0, tbl[i].exp_req});
      chk($sformatf("tbl%0d_vec", i), int_vec, tbl[i].exp_vec);
    end
    sel = 1'b0; w_en = 1'b0; irq_in = '0;

    // Priority and EOI lockout
    do_reset();
    wr(3'd0, 8'hF1); wr(3'd5, 8'h50); wr(3'd6, 8'h60);
    irq_in = 4'b0110;
    tick();
    irq_in = 4'b0000;
    tick();
    chk("prio_req1", {7'b0, int_req}, 8'h01);
    chk("prio_vec1", int_vec, 8'h50);
    tick();
    chk("prio_req1_drop", {7'b0, int_req}, 8'h00);
    rd_chk(3'd3, 8'h81, "prio_status");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("prio_locked", {7'b0, int_req}, 8'h00);
    end
    rd_chk(3'd1, 8'h04, "prio_pend");
    wr(3'd2, 8'h00);
    chk("prio_eoi_edge", {7'b0, int_req}, 8'h00);
    tick();
    chk("prio_req2", {7'b0, int_req}, 8'h01);
    chk("prio_vec2", int_vec, 8'h60);
    tick();
    chk("prio_req2_drop", {7'b0, int_req}, 8'h00);
    wr(3'd2, 8'h00);

    // Abort by clearing global enable during the request
    do_reset();
    wr(3'd0, 8'h11); wr(3'd4, 8'h33);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    wr(3'd0, 8'h10);
    chk("abort_req", {7'b0, int_req}, 8'h01);
    chk("abort_vec", int_vec, 8'h33);
    chk("abort_en", int_en, 8'h10);
    tick();
    chk("abort_drop", {7'b0, int_req}, 8'h00);
    rd_chk(3'd3, 8'h00, "abort_status");
    rd_chk(3'd1, 8'h01, "abort_pend_kept");
    sel = 1'b0; addr = 3'd0;
    #1;
    chk("unsel_rd", r_data, 8'h00);
    wr(3'd0, 8'h11);
    chk("reen_no_req_yet", {7'b0, int_req}, 8'h00);
    tick();
    chk("reissue_req", {7'b0, int_req}, 8'h01);
    chk("reissue_vec", int_vec, 8'h33);
    tick();
    rd_chk(3'd3, 8'h80, "reissue_status");
    rd_chk(3'd1, 8'h00, "reissue_pend");
    wr(3'd2, 8'h00);

    // New edge while in service is held, cleared by W1C, nothing after EOI
    do_reset();
    wr(3'd0, 8'h91);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    tick(); tick();
    rd_chk(3'd3, 8'h80, "svc_status");
    irq_in = 4'b1000;
    tick();
    irq_in = 4'b0000;
    rd_chk(3'd1, 8'h08, "svc_pend3");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("svc_no_req", {7'b0, int_req}, 8'h00);
    end
    wr(3'd1, 8'h08);
    rd_chk(3'd1, 8'h00, "svc_w1c");
    wr(3'd2, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("svc_post_eoi", {7'b0, int_req}, 8'h00);
    end
    rd_chk(3'd3, 8'h00, "svc_status_idle");

    // Asynchronous reset while requesting
    do_reset();
    wr(3'd0, 8'h11); wr(3'd4, 8'h40);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    tick();
    chk("ar_req_before", {7'b0, int_req}, 8'h01);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_req_drop", {7'b0, int_req}, 8'h00);
    chk("ar_en", int_en, 8'h00);
    chk("ar_vec", int_vec, 8'h00);
    tick();
    reset = 1'b0;
    tick();
    rd_chk(3'd0, 8'h00, "ar_ctrl");
    rd_chk(3'd1, 8'h00, "ar_pend");
    rd_chk(3'd4, 8'h00, "ar_vec0");

    // Randomized run against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      int r;
      for (int i = 0; i < 4; i++) if ($urandom_range(3) == 0) irq_in[i] = ~irq_in[i];
      r = $urandom_range(7);
      w_data = 8'($urandom);
      addr   = 3'($urandom);
      case (r)
        0, 1, 2: begin sel = 1'b0; w_en = 1'($urandom); end
        3, 4:    begin sel = 1'b1; w_en = 1'b0; end
        5:       begin sel = 1'b1; w_en = 1'b1; addr = 3'd2; end
        6: begin
          sel = 1'b1; w_en = 1'b1;
          if (addr == 3'd0 && $urandom_range(3) != 0) w_data[0] = 1'b1;
        end
        default: begin sel = 1'b1; w_en = 1'b1; addr = 3'd1; end
      endcase
      #1;
      chk("rnd_rd", r_data, model_rd());
      chk("rnd_req", {7'b0, int_req}, {7'b0, m_req});
      chk("rnd_vec", int_vec, m_vout);
      chk("rnd_en", int_en, m_ctrl);
      @(posedge clock);
      model_step();
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/int_controller.md
# int_controller

Memory-mapped interrupt controller that sits on the 8-bit core's data bus and drives the core's interrupt inputs (`int_req`, `int_en`, `int_vec`). It captures rising edges on four external request lines and prioritises them by fixed order. It issues a single-cycle request with a per-source vector, then blocks further requests until software writes end-of-interrupt (EOI). This prevents the core from being re-vectored while an ISR is running.

## Interface
- `NSRC`, 4, number of interrupt sources (fixed; register map assumes 4)
- `clock` in 1: system clock, rising edge
- `reset` in 1: asynchronous, active-high
- `irq_in` in 4: source request lines, synchronous to `clock`, rising-edge sensitive
- `sel` in 1: bus select for this block
- `addr` in 3: register address
- `w_en` in 1: bus write strobe (qualified by `sel`)
- `w_data` in 8: bus write data
- `r_data` out 8: bus read data, combinational from `addr` (0 when `sel`=0)
- `int_req` out 1: registered interrupt request to core
- `int_en` out 8: CTRL register contents to core (bit0 = global enable)
- `int_vec` out 8: registered vector address to core

## Operation
- Register map:
  - 0 CTRL, R/W: bit0 global enable; bits[7:4] per-source mask, bit4+i enables source i; bits[3:1] read 0.
  - 1 PEND, R/W1C: bits[3:0] pending.
  - 2 EOI, W: any write while in SERVICE ends service; reads 0.
  - 3 STATUS, R: bit7 in-service; bits[1:0] id of the active or last-issued source.
  - 4–7 VEC0..VEC3, R/W: 8-bit ISR address per source.
- Edge detect: register `irq_prev`. `pending[i]` sets on any edge with `irq_in[i]`=1 and `irq_prev[i]`=0, regardless of mask or state.
- Eligible set: `pending & CTRL[7:4]`, gated by `CTRL[0]`. The winner is the lowest index.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE → REQ: eligible set is nonzero. On that edge, `int_req`←1, `int_vec`←VEC[winner], `id`←winner.
  - REQ → SERVICE: the cycle's `int_en[0]`=1, i.e. the core accepted. On that edge, `int_req`←0 and `pending[id]` clears.
  - REQ → IDLE: `int_en[0]`=0 (request aborted). `int_req`←0 and `pending` is retained.
  - SERVICE → IDLE: EOI write.
- Simultaneous events:
  - A new edge on `id` in the clearing cycle wins: `pending[id]` stays 1.
  - A W1C in the same cycle as a set edge: set wins.
- Invalid writes:
  - EOI written in IDLE or REQ is ignored.
  - Writes to PEND bits[7:4] and STATUS are ignored.
- Masked-but-pending sources issue as soon as they are unmasked, provided the FSM is in IDLE.

## Timing
- Reset (async) values:
  - `int_req`=0, `int_vec`=0, CTRL=0 (hence `int_en`=0)
  - PEND=0, VEC0..3=0, `irq_prev`=0, `id`=0
  - state IDLE, `r_data`=0 when `sel`=0
- A reset asserted mid-REQ or mid-SERVICE forces IDLE immediately and drops `int_req` asynchronously.
- Latency:
  - `irq_in` rises before edge E0 → `pending` set at E0.
  - `int_req`=1 from E1 to E2, exactly one cycle.
  - Core loads `pc`←`int_vec` at E2.
- Minimum spacing between issued interrupts: EOI edge Ex → next `int_req` no earlier than Ex+1.
- Register writes take effect at the edge of the write cycle.
  - A CTRL write clearing bit0 at E1 makes REQ abort at E2.
  - A VEC write during REQ does not change the latched `int_vec`.
- `int_req` is never high in SERVICE, and never high for two consecutive cycles.

## Structure
- Shared package/header `int_ctrl_pkg` holds:
  - register address constants (ADDR_CTRL … ADDR_VEC3)
  - state encodings (ST_IDLE, ST_REQ, ST_SERVICE)
  - `NSRC`
  - CTRL bit positions (global enable bit, mask LSB)
- One sub-module, `int_prio_enc`: combinational 4→2 lowest-index encoder with a `valid` output. Everything else stays in `int_controller`.

## Test plan
- Reset → all registers read 0, `int_req`=0; with `irq_in`=4'b0001 and CTRL=0, no request ever issues and PEND reads 8'h01.
- CTRL=8'h11, VEC0=8'h40, pulse `irq_in[0]` → PEND=1 after E0, `int_req`=1 for exactly E1–E2 with `int_vec`=8'h40, STATUS=8'h80, PEND=0 after E2.
- CTRL=8'hF1, VEC1=8'h50, VEC2=8'h60, `irq_in[1]` and `irq_in[2]` rise together → vector 8'h50 first; no second request until EOI; one cycle after EOI, `int_req` with 8'h60.
- Source 0 issued; at the REQ edge write CTRL=8'h10 → abort, state IDLE, PEND bit0 still 1; rewrite CTRL=8'h11 → request reissues with the same vector.
- In SERVICE, new edge on source 3 (unmasked) → PEND=8'h08 but `int_req` stays 0; write PEND=8'h08 → cleared; EOI → no request.
- Assert `reset` while `int_req`=1 → `int_req` drops immediately; CTRL, PEND and VEC read 0 after release.
